// File: rtl/uart_receiver.sv
// 8N1 serial receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// small first-word-fall-through byte FIFO with overrun and framing-error flags.
module uart_receiver #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd_i,
    input  logic       clr_i,
    output logic [7:0] data_o,
    output logic       ready_o,
    output logic       full_o,
    output logic       frame_err_o,
    output logic       overrun_o
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

    state_t             state, state_next;
    logic               rxd_p0, rxd_p1, rxs;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         idx;
    logic [7:0]         shift;
    logic               cnt_clr, shift_en, push, ferr;
    logic               half_tick, bit_tick;

    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic [PTR_W:0]     count;
    logic               pop, wr, full;

    // Stage p0/p1: metastability guard; flops reset to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
        end
    end
    assign rxs = rxd_p1;

    assign half_tick = (cnt == CNT_W'(HALF - 1));
    assign bit_tick  = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        push       = 1'b0;
        ferr       = 1'b0;
        case (state)
            IDLE: if (!rxs) begin
                state_next = START;
                cnt_clr    = 1'b1;
            end
            START: if (half_tick) begin
                cnt_clr    = 1'b1;
                state_next = rxs ? IDLE : DATA;
            end
            DATA: if (bit_tick) begin
                cnt_clr  = 1'b1;
                shift_en = 1'b1;
                if (idx == 3'd7) state_next = STOP;
            end
            STOP: if (bit_tick) begin
                cnt_clr = 1'b1;
                if (rxs) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end else begin
                    ferr       = 1'b1;
                    state_next = WAITHI;
                end
            end
            WAITHI: if (rxs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            frame_err_o <= 1'b0;
        end else begin
            cnt         <= cnt_clr ? '0 : cnt + CNT_W'(1);
            frame_err_o <= ferr;
            if (state == START)  idx <= '0;
            else if (shift_en)   idx <= idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shift[idx] <= rxs;
    end

    // FIFO: a push while full only lands if the head is popped the same cycle
    assign full = (count == (PTR_W + 1)'(DEPTH));
    assign pop  = rd_i && (count != '0);
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + PTR_W'(1);
            if (pop) rptr <= rptr + PTR_W'(1);
            case ({wr, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) overrun_o <= 1'b1;
            else if (clr_i)           overrun_o <= 1'b0;
        end
    end

    assign ready_o = (count != '0);
    assign full_o  = full;
    assign data_o  = ready_o ? mem[rptr] : 8'h00;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: expected bytes are queued as frames are
// sent, and a negedge monitor checks every pop of the FIFO head against them.
`timescale 1ns/1ps
module tb_uart_receiver;
    localparam int BIT = 434;

    logic       clk = 1'b0;
    logic       rst, rxd, rd_i, clr_i;
    logic [7:0] data_o;
    logic       ready_o, full_o, frame_err_o, overrun_o;

    int         total  = 0;
    int         passed = 0;
    int         ferr_seen = 0;
    logic [7:0] exp_q [$];

    uart_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rd_i        (rd_i),
        .clr_i       (clr_i),
        .data_o      (data_o),
        .ready_o     (ready_o),
        .full_o      (full_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; with stop=0 the line is left low afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(BIT);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            tick(BIT);
        end
        rxd = stop;
        tick(BIT);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic pop_one();
        rd_i = 1'b1;
        tick(1);
        rd_i = 1'b0;
        tick(1);
    endtask

    always @(negedge clk) begin : monitor
        int sz;
        if (frame_err_o) ferr_seen++;
        if (!rst && rd_i && ready_o) begin
            sz = exp_q.size();
            if (sz == 0) check("sb_underflow", sz, 1);
            else         check("sb_data", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rxd = 1'b1; rd_i = 1'b0; clr_i = 1'b0;
        tick(5);
        check("rst_ready", ready_o, 0);
        check("rst_full", full_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_overrun", overrun_o, 0);
        rst = 1'b0;
        tick(10);

        // Single byte with exact ready latency
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                tick(4125);
                check("single_ready_early", ready_o, 0);
                tick(1);
                check("single_ready", ready_o, 1);
                check("single_data", data_o, 8'h55);
                rd_i = 1'b1;
                tick(1);
                rd_i = 1'b0;
                check("single_ready_after_pop", ready_o, 0);
            end
        join
        tick(20);

        // Glitch rejection
        rxd = 1'b0;
        tick(100);
        rxd = 1'b1;
        tick(300);
        check("glitch_ready", ready_o, 0);
        check("glitch_ferr", ferr_seen, 0);

        // Framing error followed by a long break
        send_frame(8'hA3, 1'b0);
        tick(2000);
        rxd = 1'b1;
        tick(50);
        check("ferr_pulses", ferr_seen, 1);
        check("ferr_fifo_empty", ready_o, 0);
        send_good(8'h3C);
        tick(10);
        check("after_ferr_ready", ready_o, 1);
        pop_one();
        check("ferr_no_more", ferr_seen, 1);

        // Overrun
        for (int i = 1; i <= 4; i++) send_good(8'(i));
        check("ovr_full_4", full_o, 1);
        check("ovr_clear_4", overrun_o, 0);
        send_frame(8'h05, 1'b1);
        check("ovr_set_5", overrun_o, 1);
        check("ovr_full_5", full_o, 1);
        for (int i = 0; i < 4; i++) pop_one();
        check("ovr_empty", ready_o, 0);
        check("ovr_sticky", overrun_o, 1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        check("ovr_cleared", overrun_o, 0);

        // Simultaneous push and pop while full
        send_good(8'h11);
        send_good(8'h22);
        send_good(8'h33);
        send_good(8'h44);
        check("simul_full_before", full_o, 1);
        exp_q.push_back(8'h77);
        fork
            send_frame(8'h77, 1'b1);
            begin
                tick(4125);
                rd_i = 1'b1;
                tick(1);
                rd_i = 1'b0;
                check("simul_overrun", overrun_o, 0);
                check("simul_full", full_o, 1);
            end
        join
        for (int i = 0; i < 4; i++) pop_one();
        check("simul_empty", ready_o, 0);

        // Reset in the middle of a frame, with a byte already buffered
        send_frame(8'h5A, 1'b1);
        check("mid_pre_ready", ready_o, 1);
        fork
            send_frame(8'hF0, 1'b1);
            begin
                tick(BIT * 5 + 200);
                rst = 1'b1;
                tick(3);
                check("mid_rst_ready", ready_o, 0);
                check("mid_rst_full", full_o, 0);
                check("mid_rst_ferr", frame_err_o, 0);
                check("mid_rst_overrun", overrun_o, 0);
                rst = 1'b0;
            end
        join
        tick(50);
        check("mid_after_ready", ready_o, 0);
        send_good(8'hC9);
        tick(10);
        check("mid_c9_ready", ready_o, 1);
        pop_one();
        check("final_ferr", ferr_seen, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
